ssram_stream_reader: RTL and testbench
======================================

# ssram_stream_reader

Read-side sequencer for one port of the 512 x 32 dual-port SSRAM. On a start command it issues a block of consecutive reads beginning at a given word address, compensates for the RAM's one-cycle registered read latency, and presents the words as a valid/ready stream. It sits between the SSRAM port B and the stream consumer, such as the JTAG shift-out data register. The writer side fills port A; this block only ever reads.

## Interface
- ADDRESS_WIDTH, 9, SSRAM word-address width (512 words).
- DATA_WIDTH, 32, SSRAM word width.
- FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.

- clock  input  1  single clock; also drives the SSRAM port clock.
- nReset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle command strobe; ignored unless idle.
- startAddress  input  ADDRESS_WIDTH  first word address, sampled with start.
- wordCount  input  ADDRESS_WIDTH+1  number of words, 0..512, sampled with start.
- abort  input  1  synchronous cancel of the running transfer.
- memAddress  output  ADDRESS_WIDTH  to SSRAM addressB; registered.
- memDataIn  input  DATA_WIDTH  from SSRAM dataOutB.
- dataOut  output  DATA_WIDTH  stream word, equal to the FIFO head.
- dataValid  output  1  stream word valid.
- dataReady  input  1  consumer accepts the word; a transfer happens on a clock edge where dataValid and dataReady are both 1.
- busy  output  1  high from the accepted start until done or abort.
- done  output  1  one-cycle pulse after the last word is transferred.

The SSRAM writeEnableB is tied to 0 at integration.

## Operation
States:
- IDLE: busy=0.
  - start=1 with wordCount=0: go to FINISH; no reads are issued.
  - start=1 with wordCount>0: load memAddress=startAddress and remaining=wordCount, then go to READ.
- READ: a read is issued at each edge where occupancy + inFlight < FIFO_DEPTH.
  - On an issue: memAddress increments modulo 2^ADDRESS_WIDTH (511 wraps to 0), remaining decrements, inFlight=1 for the next cycle.
  - When the last read issues, go to DRAIN.
- DRAIN: wait until inFlight=0 and the FIFO is empty, then go to FINISH.
- FINISH: done=1 for exactly one cycle, then go to IDLE.

Datapath:
- inFlight=1 means memDataIn holds the word read at the previous edge. That word is pushed into the FIFO at the current edge.
- The issue condition guarantees the FIFO never overflows. A push and a pop on the same edge are both honoured.
- The FIFO never re-orders words and never drops them. Words leave in address order, including across the 511 to 0 wrap.
- dataOut holds its value while dataValid=1 and dataReady=0.

Abort (in READ or DRAIN):
- At the next edge: empty the FIFO, discard any in-flight word, clear dataValid, go to IDLE.
- No done pulse is produced.
- Abort in IDLE or FINISH has no effect.

Start while busy is ignored and has no side effects.

Reset values (nReset=0, immediate):
- state=IDLE.
- memAddress=0.
- dataValid=0, busy=0, done=0.
- dataOut=0, FIFO empty, inFlight=0.
- A transfer interrupted by reset is lost entirely.

## Timing
- The start edge is E. memAddress=startAddress is valid after E.
- The first read is issued at E+1, and the first word is pushed at E+2. dataValid=1 after E+2 (latency 2 from start).
- With dataReady held at 1, one word transfers per cycle with no bubbles. N words transfer at edges E+3 .. E+N+2.
- done is high during the cycle after the edge that transfers the last word. busy falls together with done's falling edge.
- wordCount=0: done pulses in the cycle after E; busy is high only during that pulse.
- After dataReady deasserts, issuing stops within one cycle once the FIFO plus in-flight reach FIFO_DEPTH. The stream resumes on the next edge where dataReady=1.

## Test plan
- Preload words 0..7 with values 0xA0+i; start with startAddress=2 and wordCount=4, dataReady=1. Required: 0xA2, 0xA3, 0xA4, 0xA5 on consecutive edges E+3..E+6, done high during one cycle, busy=0 afterwards.
- startAddress=510, wordCount=4. Required: words from addresses 510, 511, 0, 1 in that order.
- Same transfer with dataReady toggled pseudo-randomly (50%). Required: identical word sequence, no duplicates or losses, dataOut stable while stalled, FIFO never overflows.
- wordCount=512 from address 0 with dataReady=1. Required: 512 words; the 513th address is never read; memAddress ends at 0.
- abort three cycles into a wordCount=8 transfer. Required: dataValid=0 and busy=0 after the next edge, no done; a following start with wordCount=1 returns only its own word.
- nReset pulsed low mid-transfer, and start issued while busy. Required: all outputs reach their reset values immediately; the start issued while busy does not alter the running transfer.

Source files
------------

// File: rtl/ssram_stream_reader.sv
// Read-side sequencer for one port of a 512 x 32 dual-port SSRAM.
// Issues a block of consecutive reads, absorbs the RAM's one-cycle
// registered read latency through a small FIFO, and presents the words
// as a valid/ready stream in address order.
module ssram_stream_reader #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clock,
    input  logic                     nReset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] startAddress,
    input  logic [ADDRESS_WIDTH:0]   wordCount,
    input  logic                     abort,
    output logic [ADDRESS_WIDTH-1:0] memAddress,
    input  logic [DATA_WIDTH-1:0]    memDataIn,
    output logic [DATA_WIDTH-1:0]    dataOut,
    output logic                     dataValid,
    input  logic                     dataReady,
    output logic                     busy,
    output logic                     done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]       DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDRESS_WIDTH:0] REM_ONE = (ADDRESS_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [ADDRESS_WIDTH:0]   remaining_q, remaining_d;
    logic                     in_flight_q, in_flight_d;
    logic [DATA_WIDTH-1:0]    fifo_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     data_valid_q, data_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     issue;
    logic                     push;
    logic                     pop;
    logic                     flush;
    logic [CNT_W-1:0]         fill;

    // Decode this cycle's handshake, RAM return, cancel and read-issue events.
    always_comb begin
        pop   = data_valid_q && dataReady;
        push  = in_flight_q;
        flush = abort && (state_q == ST_READ || state_q == ST_DRAIN);
        // Words already buffered plus the one still coming back from the RAM
        // must leave room for the word this read will return.
        fill  = count_q + CNT_W'(in_flight_q);
        issue = (state_q == ST_READ) && !abort && (fill < DEPTH_C);
    end

    // Next-state logic for the sequencer, the FIFO and the registered outputs.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d       = state_q;
        mem_address_d = mem_address_q;
        remaining_d   = remaining_q;
        in_flight_d   = issue;
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (flush) begin
            // Cancel: drop buffered words and the word still in the RAM pipe.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            in_flight_d = 1'b0;
            state_d     = ST_IDLE;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = memDataIn;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (wordCount == '0) begin
                            state_d = ST_FINISH;
                        end else begin
                            mem_address_d = startAddress;
                            remaining_d   = wordCount;
                            state_d       = ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        // Address wraps naturally from the top word to 0.
                        mem_address_d = mem_address_q + 1'b1;
                        remaining_d   = remaining_q - 1'b1;
                        if (remaining_q == REM_ONE) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Finish on the edge that hands over the last word so
                    // done appears in the very next cycle.
                    if (!in_flight_q && count_d == '0) begin
                        state_d = ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        data_valid_d = (count_d != '0);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_FINISH);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge nReset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!nReset) begin
            state_q       <= ST_IDLE;
            mem_address_q <= '0;
            remaining_q   <= '0;
            in_flight_q   <= 1'b0;
            // NOTE: the FIFO storage is reset as well because its head drives
            // dataOut, which must read 0 out of reset; it is only a few words.
            fifo_q        <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            data_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_address_q <= mem_address_d;
            remaining_q   <= remaining_d;
            in_flight_q   <= in_flight_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            data_valid_q  <= data_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign memAddress = mem_address_q;
    assign dataOut    = fifo_q[rd_ptr_q];
    assign dataValid  = data_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ssram_stream_reader.sv
// Bench for ssram_stream_reader: an SSRAM model behind port B, a queue-based
// model of the expected word stream, and a per-cycle compare process.
module tb_ssram_stream_reader;

    logic        clock = 1'b0;
    logic        nReset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  startAddress = '0;
    logic [9:0]  wordCount = '0;
    logic        abort = 1'b0;
    logic [8:0]  memAddress;
    logic [31:0] memDataIn;
    logic [31:0] dataOut;
    logic        dataValid;
    logic        dataReady = 1'b0;
    logic        busy;
    logic        done;

    ssram_stream_reader dut (
        .clock        (clock),
        .nReset       (nReset),
        .start        (start),
        .startAddress (startAddress),
        .wordCount    (wordCount),
        .abort        (abort),
        .memAddress   (memAddress),
        .memDataIn    (memDataIn),
        .dataOut      (dataOut),
        .dataValid    (dataValid),
        .dataReady    (dataReady),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    // SSRAM port B: one-cycle registered read.
    logic [31:0] ram [512];
    logic [31:0] mem_rd = '0;
    always @(posedge clock) mem_rd <= ram[memAddress];
    assign memDataIn = mem_rd;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_ref_cyc = -1;
    int done_pulses = 0;
    bit stalled_prev = 1'b0;
    logic [31:0] held_word = '0;
    logic [31:0] exp_q[$];
    logic [31:0] got_words[$];
    int          got_cyc[$];

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: stream words, stall stability and done timing.
    always @(negedge clock) begin
        if (nReset) begin
            if (dataValid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", dataValid, 1'b0);
                end else begin
                    check("stream_word", dataOut, exp_q[0]);
                    if (stalled_prev) check("stall_hold", dataOut, held_word);
                    if (dataReady) begin
                        got_words.push_back(dataOut);
                        got_cyc.push_back(cyc + 1);
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) done_ref_cyc = cyc + 1;
                    end
                end
                held_word    = dataOut;
                stalled_prev = !dataReady;
            end else begin
                if (stalled_prev) check("stall_valid", dataValid, 1'b1);
                stalled_prev = 1'b0;
            end
            if (done) begin
                done_pulses++;
                check("done_cycle", cyc, done_ref_cyc);
                check("done_after_last", exp_q.size(), 0);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input int addr, input int n);
        start        = 1'b1;
        startAddress = 9'(addr);
        wordCount    = 10'(n);
        for (int i = 0; i < n; i++) exp_q.push_back(ram[(addr + i) % 512]);
        if (n == 0) done_ref_cyc = cyc + 1;
        step();
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int max_cyc, input bit rand_rdy);
        int p0 = done_pulses;
        int k = 0;
        while (done_pulses == p0 && k < max_cyc) begin
            if (rand_rdy) dataReady = 1'($urandom_range(1, 0));
            step();
            k++;
        end
        dataReady = 1'b1;
        check("done_pulse_seen", done_pulses - p0, 1);
        check("busy_after_done", busy, 1'b0);
        check("done_single", done, 1'b0);
    endtask

    task automatic clear_got();
        got_words.delete();
        got_cyc.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_memAddress"}, memAddress, 9'd0);
        check({tag, "_dataValid"}, dataValid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_dataOut"}, dataOut, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] wrap_exp [4];
        int p0;
        wrap_exp = '{32'hC0DE01FE, 32'hC0DE01FF, 32'h000000A0, 32'h000000A1};

        for (int i = 0; i < 512; i++) begin
            if (i < 8) ram[i] = 32'hA0 + 32'(i);
            else       ram[i] = {16'hC0DE, 16'(i)};
        end

        // Reset state.
        #2 nReset = 1'b0;
        #1 check_reset_outputs("reset");
        step();
        step();
        nReset = 1'b1;
        dataReady = 1'b1;
        step();

        // Basic 4-word transfer from address 2.
        clear_got();
        do_start(2, 4);
        wait_done(40, 1'b0);
        check("t1_count", got_words.size(), 4);
        for (int i = 0; i < 4 && i < got_words.size(); i++) begin
            check("t1_word", got_words[i], 32'hA2 + 32'(i));
            check("t1_edge", got_cyc[i], start_cyc + 3 + i);
        end

        // Zero-length transfer: done in the cycle after start, no reads.
        do_start(0, 0);
        check("t0_done", done, 1'b1);
        check("t0_busy", busy, 1'b1);
        check("t0_valid", dataValid, 1'b0);
        step();
        check("t0_done_low", done, 1'b0);
        check("t0_busy_low", busy, 1'b0);

        // Address wrap 510 -> 1.
        clear_got();
        do_start(510, 4);
        wait_done(40, 1'b0);
        check("wrap_count", got_words.size(), 4);
        for (int i = 0; i < 4 && i < got_words.size(); i++)
            check("wrap_word", got_words[i], wrap_exp[i]);

        // Same wrap transfer under random back-pressure.
        clear_got();
        do_start(510, 4);
        wait_done(200, 1'b1);
        check("wrap_rand_count", got_words.size(), 4);
        for (int i = 0; i < 4 && i < got_words.size(); i++)
            check("wrap_rand_word", got_words[i], wrap_exp[i]);

        // Longer random back-pressure run that keeps the FIFO full.
        clear_got();
        do_start(504, 16);
        wait_done(400, 1'b1);
        check("rand16_count", got_words.size(), 16);

        // Full 512-word transfer from address 0.
        clear_got();
        do_start(0, 512);
        wait_done(700, 1'b0);
        check("full_count", got_words.size(), 512);
        check("full_first_edge", got_cyc.size() > 0 ? got_cyc[0] : -1, start_cyc + 3);
        check("full_last_edge", got_cyc.size() > 0 ? got_cyc[got_cyc.size() - 1] : -1, start_cyc + 514);
        check("full_addr_end", memAddress, 9'd0);

        // Abort three cycles into an 8-word transfer.
        clear_got();
        do_start(0, 8);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_q.delete();
        stalled_prev = 1'b0;
        check("abort_valid", dataValid, 1'b0);
        check("abort_busy", busy, 1'b0);
        p0 = done_pulses;
        repeat (6) step();
        check("abort_no_done", done_pulses - p0, 0);
        check("abort_idle_valid", dataValid, 1'b0);
        clear_got();
        do_start(5, 1);
        wait_done(40, 1'b0);
        check("after_abort_count", got_words.size(), 1);
        if (got_words.size() > 0) check("after_abort_word", got_words[0], 32'hA5);

        // Start while busy (once in READ, once later) must not disturb it.
        clear_got();
        do_start(100, 8);
        step();
        start = 1'b1; startAddress = 9'd300; wordCount = 10'd3;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1; startAddress = 9'd400; wordCount = 10'd0;
        step();
        start = 1'b0;
        wait_done(60, 1'b0);
        check("busy_start_count", got_words.size(), 8);
        for (int i = 0; i < 8 && i < got_words.size(); i++)
            check("busy_start_word", got_words[i], 32'hC0DE0064 + 32'(i));
        check("busy_start_addr", memAddress, 9'd108);

        // Reset mid-transfer: outputs clear immediately, transfer is lost.
        do_start(20, 10);
        repeat (3) step();
        #2 nReset = 1'b0;
        exp_q.delete();
        stalled_prev = 1'b0;
        #1 check_reset_outputs("midreset");
        step();
        step();
        nReset = 1'b1;
        p0 = done_pulses;
        repeat (4) step();
        check("post_reset_busy", busy, 1'b0);
        check("post_reset_valid", dataValid, 1'b0);
        check("post_reset_no_done", done_pulses - p0, 0);
        clear_got();
        do_start(7, 2);
        wait_done(40, 1'b0);
        check("recover_count", got_words.size(), 2);
        if (got_words.size() > 1) begin
            check("recover_word0", got_words[0], 32'hA7);
            check("recover_word1", got_words[1], 32'hC0DE0008);
        end

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
